// File: rtl/alu_cmd_master.sv
// alu_cmd_master: bus initiator that runs one complete ALU job per accepted command.
// Writes operands, opcode and start, polls status, reads the 64-bit result, then
// clears the slave and returns {hi, lo} with a timeout flag.
module alu_cmd_master #(
    parameter int          TIMEOUT = 1024,
    parameter logic [7:0]  BASE    = 8'h30
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_a,
    input  logic [31:0] cmd_b,
    input  logic [3:0]  cmd_op,
    output logic        res_valid,
    output logic [63:0] res_data,
    output logic        res_err,
    output logic        M_sel,
    output logic        M_wr,
    output logic [7:0]  M_addr,
    output logic [31:0] M_dout,
    input  logic [31:0] M_din
);

    typedef enum logic [3:0] {
        IDLE, WR_A, WR_B, WR_OP, WR_GO, POLL_ADR, POLL_CAP,
        RD_LO_ADR, RD_LO_CAP, RD_HI_ADR, RD_HI_CAP, CLR_SET, CLR_REL, DONE
    } state_t;

    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] POLL_MAX = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [31:0]   b_q;
    logic [3:0]    op_q;
    logic [31:0]   lo_q, hi_q;
    logic [CW-1:0] poll_q;
    logic          err_q;
    logic          res_valid_q, res_err_q;
    logic [63:0]   res_data_q;

    logic          sel_q, wr_q, sel_d, wr_d;
    logic [7:0]    addr_q, addr_d;
    logic [31:0]   dout_q, dout_d;
    logic [2:0]    off_d;

    logic          accept;
    logic          poll_last;

    // Ready is withheld while reset is asserted so nothing is accepted on the reset edge.
    assign cmd_ready = reset_n && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign poll_last = (poll_q == POLL_MAX);

    // State and bus registers; bus outputs are computed from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            sel_q   <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= 8'h00;
            dout_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            dout_q  <= dout_d;
        end
    end

    // Next-state: one bus cycle per state, status poll loops until done or the poll budget runs out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (accept) state_d = WR_A;
            WR_A:      state_d = WR_B;
            WR_B:      state_d = WR_OP;
            WR_OP:     state_d = WR_GO;
            WR_GO:     state_d = POLL_ADR;
            POLL_ADR:  state_d = POLL_CAP;
            POLL_CAP: begin
                if (M_din[0])        state_d = RD_LO_ADR;
                else if (!poll_last) state_d = POLL_ADR;
                else                 state_d = CLR_SET;
            end
            RD_LO_ADR: state_d = RD_LO_CAP;
            RD_LO_CAP: state_d = RD_HI_ADR;
            RD_HI_ADR: state_d = RD_HI_CAP;
            RD_HI_CAP: state_d = CLR_SET;
            CLR_SET:   state_d = CLR_REL;
            CLR_REL:   state_d = DONE;
            DONE:      state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Bus cycle for the upcoming state; WR_A takes operand A straight from the port on the accept edge.
    always_comb begin
        sel_d  = 1'b0;
        wr_d   = 1'b0;
        off_d  = 3'd0;
        dout_d = 32'h0;
        case (state_d)
            WR_A:      begin sel_d = 1'b1; wr_d = 1'b1; off_d = 3'd0; dout_d = cmd_a; end
            WR_B:      begin sel_d = 1'b1; wr_d = 1'b1; off_d = 3'd1; dout_d = b_q; end
            WR_OP:     begin sel_d = 1'b1; wr_d = 1'b1; off_d = 3'd2; dout_d = {28'h0, op_q}; end
            WR_GO:     begin sel_d = 1'b1; wr_d = 1'b1; off_d = 3'd3; dout_d = 32'h1; end
            POLL_ADR,
            POLL_CAP:  begin sel_d = 1'b1; off_d = 3'd4; end
            RD_LO_ADR,
            RD_LO_CAP: begin sel_d = 1'b1; off_d = 3'd6; end
            RD_HI_ADR,
            RD_HI_CAP: begin sel_d = 1'b1; off_d = 3'd7; end
            CLR_SET:   begin sel_d = 1'b1; wr_d = 1'b1; off_d = 3'd5; dout_d = 32'h1; end
            CLR_REL:   begin sel_d = 1'b1; wr_d = 1'b1; off_d = 3'd5; dout_d = 32'h0; end
            default:   ;
        endcase
        addr_d = sel_d ? (BASE + 8'(off_d)) : 8'h00;
    end

    // Datapath: latch command, count polls, capture read data in CAP cycles, publish result in DONE.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            b_q         <= 32'h0;
            op_q        <= 4'h0;
            lo_q        <= 32'h0;
            hi_q        <= 32'h0;
            poll_q      <= '0;
            err_q       <= 1'b0;
            res_valid_q <= 1'b0;
            res_data_q  <= 64'h0;
            res_err_q   <= 1'b0;
        end else begin
            res_valid_q <= (state_d == DONE);
            if (accept) begin
                b_q    <= cmd_b;
                op_q   <= cmd_op;
                poll_q <= '0;
                err_q  <= 1'b0;
            end
            if (state_q == POLL_CAP && !M_din[0]) begin
                if (!poll_last) poll_q <= poll_q + 1'b1;
                else            err_q  <= 1'b1;
            end
            if (state_q == RD_LO_CAP) lo_q <= M_din;
            if (state_q == RD_HI_CAP) hi_q <= M_din;
            if (state_d == DONE) begin
                res_data_q <= err_q ? 64'h0 : {hi_q, lo_q};
                res_err_q  <= err_q;
            end
        end
    end

    assign M_sel     = sel_q;
    assign M_wr      = wr_q;
    assign M_addr    = addr_q;
    assign M_dout    = dout_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_cmd_master.sv
module tb_alu_cmd_master;

    localparam logic [7:0] BASE = 8'h30;
    localparam int T0 = 1024;
    localparam int T1 = 8;

    typedef struct packed {
        logic        wr;
        logic [7:0]  addr;
        logic [31:0] data;
    } bus_t;

    logic        clk, reset_n;
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [31:0] cmd_a     [2];
    logic [31:0] cmd_b     [2];
    logic [3:0]  cmd_op    [2];
    logic        res_valid [2];
    logic [63:0] res_data  [2];
    logic        res_err   [2];
    logic        M_sel     [2];
    logic        M_wr      [2];
    logic [7:0]  M_addr    [2];
    logic [31:0] M_dout    [2];
    logic [31:0] M_din     [2];

    int          done_after [2];
    logic [31:0] s_lo [2];
    logic [31:0] s_hi [2];
    int          stat_cnt [2];

    int   tests = 0;
    int   fails = 0;
    bus_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : g_dut
        alu_cmd_master #(.TIMEOUT(g == 0 ? T0 : T1), .BASE(BASE)) u_dut (
            .clk      (clk),
            .reset_n  (reset_n),
            .cmd_valid(cmd_valid[g]),
            .cmd_ready(cmd_ready[g]),
            .cmd_a    (cmd_a[g]),
            .cmd_b    (cmd_b[g]),
            .cmd_op   (cmd_op[g]),
            .res_valid(res_valid[g]),
            .res_data (res_data[g]),
            .res_err  (res_err[g]),
            .M_sel    (M_sel[g]),
            .M_wr     (M_wr[g]),
            .M_addr   (M_addr[g]),
            .M_dout   (M_dout[g]),
            .M_din    (M_din[g])
        );

        // Slave: registered read data, so data is valid in the second cycle the address is held.
        // Status reports done from the done_after-th poll onwards (done_after = 0 means never).
        always @(posedge clk) begin
            if (cmd_valid[g] && cmd_ready[g]) begin
                stat_cnt[g] <= 0;
            end else if (M_sel[g] && !M_wr[g]) begin
                if (M_addr[g] == BASE + 8'd4) begin
                    M_din[g]    <= {31'b0, (done_after[g] > 0) && (stat_cnt[g] / 2 + 1 >= done_after[g])};
                    stat_cnt[g] <= stat_cnt[g] + 1;
                end else if (M_addr[g] == BASE + 8'd6) begin
                    M_din[g] <= s_lo[g];
                end else if (M_addr[g] == BASE + 8'd7) begin
                    M_din[g] <= s_hi[g];
                end else begin
                    M_din[g] <= 32'h0;
                end
            end
        end
    end

    function automatic bus_t mk(input logic wr, input logic [7:0] off, input logic [31:0] d);
        bus_t e;
        e.wr   = wr;
        e.addr = BASE + off;
        e.data = d;
        return e;
    endfunction

    task automatic check_reset_outputs();
        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", cmd_ready[g], 1'b0);
            chk("rst_sel",   M_sel[g],     1'b0);
            chk("rst_wr",    M_wr[g],      1'b0);
            chk("rst_addr",  M_addr[g],    8'h00);
            chk("rst_dout",  M_dout[g],    32'h0);
            chk("rst_rv",    res_valid[g], 1'b0);
            chk("rst_rdata", res_data[g],  64'h0);
            chk("rst_rerr",  res_err[g],   1'b0);
        end
    endtask

    // One job: build the expected bus-cycle list from the register map, run it, compare cycle by cycle.
    // hold keeps cmd_valid asserted after acceptance; pre means the command is already on the inputs.
    task automatic run_job(input int g, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                           input int dn, input logic [31:0] lo, input logic [31:0] hi,
                           input bit hold, input bit pre);
        int          tmo, n, lat, wt;
        bit          ok_done, seen;
        bus_t        e;
        logic [63:0] exp_res;
        tmo     = (g == 0) ? T0 : T1;
        ok_done = (dn > 0) && (dn <= tmo);
        n       = ok_done ? dn : tmo;
        exp_res = ok_done ? {hi, lo} : 64'h0;
        lat     = ok_done ? (4 + 2 * n + 4 + 2 + 1) : (4 + 2 * n + 2 + 1);
        exp_q.delete();
        exp_q.push_back(mk(1'b1, 8'd0, a));
        exp_q.push_back(mk(1'b1, 8'd1, b));
        exp_q.push_back(mk(1'b1, 8'd2, {28'h0, op}));
        exp_q.push_back(mk(1'b1, 8'd3, 32'h1));
        for (int i = 0; i < 2 * n; i++) exp_q.push_back(mk(1'b0, 8'd4, 32'h0));
        if (ok_done) begin
            exp_q.push_back(mk(1'b0, 8'd6, 32'h0));
            exp_q.push_back(mk(1'b0, 8'd6, 32'h0));
            exp_q.push_back(mk(1'b0, 8'd7, 32'h0));
            exp_q.push_back(mk(1'b0, 8'd7, 32'h0));
        end
        exp_q.push_back(mk(1'b1, 8'd5, 32'h1));
        exp_q.push_back(mk(1'b1, 8'd5, 32'h0));
        done_after[g] = dn;
        s_lo[g]       = lo;
        s_hi[g]       = hi;
        if (!pre) begin
            wt = 0;
            while (!cmd_ready[g] && wt < 50) begin
                @(negedge clk);
                wt++;
            end
            chk("ready_wait", cmd_ready[g], 1'b1);
            cmd_a[g]     = a;
            cmd_b[g]     = b;
            cmd_op[g]    = op;
            cmd_valid[g] = 1'b1;
        end else begin
            chk("pre_ready", cmd_ready[g], 1'b1);
        end
        @(posedge clk);
        if (!hold) begin
            #1;
            cmd_valid[g] = 1'b0;
            cmd_a[g]     = ~a;
            cmd_b[g]     = ~b;
            cmd_op[g]    = ~op;
        end
        seen = 1'b0;
        for (int cyc = 1; cyc <= lat + 4 && !seen; cyc++) begin
            @(negedge clk);
            chk("busy_ready", cmd_ready[g], 1'b0);
            if (M_sel[g]) begin
                chk("bus_extra", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("bus_wr",   M_wr[g],   e.wr);
                    chk("bus_addr", M_addr[g], e.addr);
                    if (e.wr) chk("bus_wdata", M_dout[g], e.data);
                end
            end
            if (res_valid[g]) begin
                seen = 1'b1;
                chk("latency",  cyc,         lat);
                chk("res_data", res_data[g], exp_res);
                chk("res_err",  res_err[g],  !ok_done);
                chk("done_sel", M_sel[g],    1'b0);
            end
        end
        chk("res_seen",   seen,         1'b1);
        chk("bus_left",   exp_q.size(), 0);
        @(negedge clk);
        chk("pulse_1cyc", res_valid[g], 1'b0);
        chk("res_hold",   res_data[g],  exp_res);
        chk("idle_ready", cmd_ready[g], 1'b1);
        chk("idle_sel",   M_sel[g],     1'b0);
    endtask

    initial begin
        reset_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            cmd_valid[g]  = 1'b0;
            cmd_a[g]      = 32'h0;
            cmd_b[g]      = 32'h0;
            cmd_op[g]     = 4'h0;
            done_after[g] = 0;
            s_lo[g]       = 32'h0;
            s_hi[g]       = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel_ready", cmd_ready[0], 1'b1);

        // Reset held three cycles in the middle of WR_B abandons the job without a clear write.
        cmd_a[0] = 32'h11; cmd_b[0] = 32'h22; cmd_op[0] = 4'h1; cmd_valid[0] = 1'b1;
        @(posedge clk); #1 cmd_valid[0] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("mid_wrb_addr", M_addr[0], BASE + 8'd1);
        reset_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs();
        end
        reset_n = 1'b1;
        @(negedge clk);
        chk("rel2_ready", cmd_ready[0], 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk("rel2_sel", M_sel[0], 1'b0);
        end

        // NOT A, done on the first poll
        run_job(0, 32'd3, 32'd2, 4'b0000, 1, 32'hFFFF_FFFC, 32'h0, 1'b0, 1'b0);
        // add, done after 20 polls
        run_job(0, 32'd7, 32'd5, 4'b1101, 20, 32'd12, 32'h0, 1'b0, 1'b0);
        // multiply with a carry into the high word
        run_job(0, 32'h0000_0003, 32'h8000_0000, 4'b1110, 2, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0);
        // short poll budget: never done -> timeout after 8 reads; done exactly on the last allowed poll
        run_job(1, 32'hA5A5_0001, 32'h5A5A_0002, 4'b0011, 0, 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b0, 1'b0);
        run_job(1, 32'h0000_0010, 32'h0000_0020, 4'b1101, 8, 32'h0000_0030, 32'h0, 1'b0, 1'b0);
        run_job(1, 32'h1, 32'h2, 4'b1101, 9, 32'h3, 32'h4, 1'b0, 1'b0);
        // cmd_valid held through two jobs: second is accepted only out of IDLE
        run_job(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0101, 1, 32'h0BAD_F00D, 32'h0000_0042, 1'b1, 1'b0);
        run_job(0, 32'h1234_5678, 32'h9ABC_DEF0, 4'b0101, 1, 32'h0BAD_F00D, 32'h0000_0042, 1'b0, 1'b1);
        // randomised jobs
        for (int r = 0; r < 6; r++) begin
            run_job(r % 2, $urandom, $urandom, 4'($urandom), $urandom_range(1, 6), $urandom, $urandom, 1'b0, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_cmd_master.md
Name: alu_cmd_master

Overview:
- Bus-initiator for the ALU-with-multiplier slave; drives the other end of its S_sel/S_wr/S_addr/S_din/S_dout register interface.
- Accepts one operation per valid/ready handshake and performs the full transaction: write operands, opcode and start; poll status; read the 64-bit result; clear.
- Returns the result with an error flag. Sits between a host/sequencer and the ALU slave.

Parameters:
- TIMEOUT, 1024, max status-poll reads before aborting with err.
- BASE, 8'h30, slave register block base address.

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command request
- cmd_ready  out  1  high in IDLE only
- cmd_a  in  32  operand A
- cmd_b  in  32  operand B
- cmd_op  in  4  opcode
- res_valid  out  1  one-cycle result pulse
- res_data  out  64  {hi, lo} result; held until next res_valid
- res_err  out  1  timeout flag, valid with res_valid
- M_sel  out  1  slave select
- M_wr  out  1  1 = write, 0 = read
- M_addr  out  8  register address
- M_dout  out  32  write data, to slave S_din
- M_din  in  32  read data, from slave S_dout

Behaviour:
- Register map (offsets from BASE): +0 operand A, +1 operand B, +2 opcode, +3 opstart (bit0), +4 status (bit0 = done), +5 clear (bit0), +6 result low, +7 result high.
- Reset (sync, reset_n = 0 at a rising edge):
  - State returns to IDLE.
  - M_sel = 0, M_wr = 0, M_addr = 0, M_dout = 0.
  - cmd_ready = 0 during reset, 1 from the first cycle after release.
  - res_valid = 0, res_data = 0, res_err = 0; poll counter = 0.
  - Reset mid-transaction abandons it; no clear write is issued.
- Handshake: the command is taken on the edge where cmd_valid && cmd_ready. cmd_a, cmd_b, cmd_op are latched internally; inputs are ignored afterwards.
- All M_* outputs are registered. Each state drives exactly one bus cycle. M_sel = 1 in every bus state, 0 in IDLE and DONE.
- FSM sequence, one cycle per state unless noted:
  - IDLE -> WR_A (wr, +0, A) -> WR_B (+1, B) -> WR_OP (+2, {28'b0, op}) -> WR_GO (+3, 1).
  - -> POLL_ADR (rd, +4) -> POLL_CAP (rd, +4; samples M_din at the end of this cycle).
  - If done = 1: go to RD_LO_ADR.
  - If done = 0 and the counter is below TIMEOUT-1: increment the counter and return to POLL_ADR.
  - Otherwise: set err and go to CLR_SET.
  - RD_LO_ADR/RD_LO_CAP (+6) -> RD_HI_ADR/RD_HI_CAP (+7). Same 2-cycle read; data is sampled in the CAP cycle.
  - -> CLR_SET (wr, +5, 1) -> CLR_REL (wr, +5, 0) -> DONE -> IDLE.
- Read timing: the slave's S_dout is valid by the second cycle the address is held. The master never samples M_din in an ADR cycle.
- DONE cycle:
  - res_valid = 1 for exactly one cycle.
  - res_data = {hi, lo}; on timeout res_data = 0 and res_err = 1.
- Best-case latency, accept edge to res_valid: 4 writes + 2 poll + 4 read + 2 clear + DONE = res_valid in the 13th cycle after acceptance.
- Poll counter clears on each command accept. Wrap is impossible because the counter saturates at TIMEOUT-1.
- cmd_valid asserted outside IDLE is ignored; no queueing.
- A command is accepted only in IDLE, so no new command can be accepted in the same cycle as res_valid (DONE).
- Opcode upper bits [31:4] are always written as zero.

Test Plan:
1. Reset held 3 cycles mid-WR_B -> all outputs 0 during reset; cmd_ready = 1 the cycle after release; M_sel stays 0.
2. cmd A = 3, B = 2, op = 4'b0000 (NOT A); slave done after 1 poll, lo = 32'hFFFF_FFFC, hi = 0 -> bus writes 0x30=3, 0x31=2, 0x32=0, 0x33=1; reads 0x34, 0x36, 0x37; writes 0x35=1 then 0x35=0; res_data = 64'h0000_0000_FFFF_FFFC; res_err = 0; res_valid exactly 1 cycle.
3. cmd A = 7, B = 5, op = 4'b1101 (add); done after 20 polls -> 20 POLL_ADR/POLL_CAP pairs; res_data = 64'd12; latency 13 + 2×19 cycles.
4. Multiply; slave returns hi = 32'h0000_0001, lo = 32'h8000_0000 -> res_data = 64'h0000_0001_8000_0000.
5. TIMEOUT = 8, slave never sets done -> exactly 8 status reads, then clear writes; res_err = 1, res_data = 0.
6. cmd_valid held high continuously through two jobs -> second job accepted only on the cycle after DONE (in IDLE); no bus activity overlaps.
